// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its farm-road sensor front end.
// The lamp encodings are one-hot and are used for both the highway and the farm road.
package traffic_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_PRESENT,
    ST_RELEASE,
    ST_HOLD
  } sensor_state_t;

  function automatic logic is_green(input logic [2:0] lamp);
    return lamp == LAMP_GREEN;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Reset is synchronous and active-high; both stages clear to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Debounces the farm-road vehicle loop and latches the request until the farm road has
// been shown green. Also counts qualified arrivals and flags a loop that stays occupied.
module farm_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int STUCK_CYC = 1000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loop_raw,
  input  logic [2:0]       farm,
  output logic             sensor,
  output logic [CNT_W-1:0] car_count,
  output logic             stuck
);

  localparam int QW = $clog2(DEBOUNCE + 1);
  localparam int DW = $clog2(STUCK_CYC + 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] STUCK_LAST = DW'(STUCK_CYC - 1);

  logic          loop_s;
  logic          green;
  sensor_state_t state_reg;
  logic [QW-1:0] cnt_reg;
  logic [DW-1:0] dwell_reg;
  logic          served_reg;
  logic          sensor_reg;
  logic [CNT_W-1:0] count_reg;
  logic          stuck_reg;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (loop_raw),
    .q     (loop_s)
  );

  assign green = is_green(farm);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      served_reg <= 1'b0;
      sensor_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (loop_s) begin
            state_reg <= ST_QUALIFY;
            cnt_reg   <= QW'(1);
          end
        end
        ST_QUALIFY: begin
          if (!loop_s) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == QUAL_LAST) begin
            state_reg  <= ST_PRESENT;
            sensor_reg <= 1'b1;
            served_reg <= 1'b0;
            cnt_reg    <= '0;
            if (count_reg != '1)
              count_reg <= count_reg + 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_PRESENT: begin
          if (green)
            served_reg <= 1'b1;
          if (!loop_s) begin
            state_reg <= ST_RELEASE;
            cnt_reg   <= QW'(1);
          end
        end
        ST_RELEASE: begin
          if (green)
            served_reg <= 1'b1;
          if (loop_s) begin
            // Loop bounced back on: same vehicle, keep the served history.
            state_reg <= ST_PRESENT;
            cnt_reg   <= '0;
          end else if (cnt_reg == QUAL_LAST) begin
            cnt_reg <= '0;
            if (served_reg || green) begin
              state_reg  <= ST_IDLE;
              sensor_reg <= 1'b0;
            end else begin
              state_reg <= ST_HOLD;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          if (green) begin
            state_reg  <= ST_IDLE;
            sensor_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          cnt_reg    <= '0;
          sensor_reg <= 1'b0;
        end
      endcase
    end
  end

  // Dwell only accumulates across an unbroken PRESENT stay; stuck is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_reg <= '0;
      stuck_reg <= 1'b0;
    end else if (state_reg == ST_PRESENT) begin
      if (dwell_reg != '1)
        dwell_reg <= dwell_reg + 1'b1;
      if (dwell_reg >= STUCK_LAST)
        stuck_reg <= 1'b1;
    end else begin
      dwell_reg <= '0;
    end
  end

  assign sensor    = sensor_reg;
  assign car_count = count_reg;
  assign stuck     = stuck_reg;

endmodule
